// File: rtl/rr_mux_arbiter_pkg.sv
// Package: rr_mux_arbiter_pkg
// Shared definitions for the round-robin mux arbiter:
//   ARB_IDLE / ARB_FULL  - output-register FSM state encodings
//   arb_num_req()        - number of requesters N for a given select width
package rr_mux_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_FULL = 1'b1;

  function automatic int unsigned arb_num_req(input int unsigned sel_w);
    return int'(1) << sel_w;
  endfunction

endpackage

// File: rtl/Mux.sv
// Module: Mux
// N:1 word multiplexer (N = 2**SELECT_WIDTH).
// Ports:
//   i_sel   - index of the word to pass through
//   i_data  - packed words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_data  - selected word
module Mux
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned SELECT_WIDTH = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  localparam int unsigned N           = arb_num_req(SELECT_WIDTH)
) (
  input  logic [SELECT_WIDTH-1:0] i_sel,
  input  logic [N*DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_sel == SELECT_WIDTH'(i)) o_data = i_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_picker.sv
// Module: rr_mux_arbiter_picker
// Combinational round-robin pick: first set request at or after index ptr+1, wrapping.
// Ports:
//   i_req     - request vector
//   i_ptr     - index of the last winner; search starts just above it
//   o_winner  - winning index (valid only when o_any)
//   o_any     - at least one request is pending
module rr_mux_arbiter_picker
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned SELECT_WIDTH = 3,
  localparam int unsigned N           = arb_num_req(SELECT_WIDTH)
) (
  input  logic [N-1:0]            i_req,
  input  logic [SELECT_WIDTH-1:0] i_ptr,
  output logic [SELECT_WIDTH-1:0] o_winner,
  output logic                    o_any
);

  logic [SELECT_WIDTH:0]   w_shift;
  logic [N-1:0]            w_rot;
  logic [SELECT_WIDTH-1:0] w_offset;

  // Shift amount ptr+1 may equal N (ptr = N-1), which leaves req unrotated.
  assign w_shift = {1'b0, i_ptr} + (SELECT_WIDTH+1)'(1);

  always_comb begin
    // Bit 0 of the rotated vector corresponds to requester ptr+1.
    w_rot    = N'({i_req, i_req} >> w_shift);
    w_offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_offset = SELECT_WIDTH'(i);
    end
  end

  // Modulo-N wrap falls out of the SELECT_WIDTH-bit addition.
  assign o_winner = i_ptr + SELECT_WIDTH'(1) + w_offset;
  assign o_any    = |i_req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Module: rr_mux_arbiter
// Round-robin arbiter sharing one DATA_WIDTH datapath among N = 2**SELECT_WIDTH requesters.
// The chosen word is registered and offered downstream on a valid/ready handshake.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   req, datas  - per-requester pending flag and word (word i at [i*DATA_WIDTH +: DATA_WIDTH])
//   lock        - (ARB_LOCK_EN only) lock[i]=1 asks to keep the grant for the next capture
//   gnt         - one-hot, combinational; high in the cycle requester i's word is captured
//   out_valid, out_ready, out_data, out_sel - downstream handshake, registered word and source
// Configuration: define ARB_LOCK_EN to add the lock port and burst ownership.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned SELECT_WIDTH = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  localparam int unsigned N           = arb_num_req(SELECT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  input  logic [N*DATA_WIDTH-1:0] datas,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]            lock,
`endif
  output logic [N-1:0]            gnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [SELECT_WIDTH-1:0] out_sel
);

  logic [0:0]              r_state;
  logic [SELECT_WIDTH-1:0] r_ptr;
  logic [SELECT_WIDTH-1:0] r_sel;
  logic [DATA_WIDTH-1:0]   r_data;

  logic [SELECT_WIDTH-1:0] w_pick_winner;
  logic [SELECT_WIDTH-1:0] w_winner;
  logic                    w_any;
  logic                    w_cap;
  logic                    w_fire;
  logic [DATA_WIDTH-1:0]   w_mux_data;

  rr_mux_arbiter_picker #(
    .SELECT_WIDTH(SELECT_WIDTH)
  ) u_picker (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_winner(w_pick_winner),
    .o_any   (w_any)
  );

`ifdef ARB_LOCK_EN
  logic r_lock_hold;

  // A held lock overrides rotation only while its owner keeps requesting.
  assign w_winner = (r_lock_hold & req[r_ptr]) ? r_ptr : w_pick_winner;
`else
  assign w_winner = w_pick_winner;
`endif

  Mux #(
    .SELECT_WIDTH(SELECT_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_mux (
    .i_sel (w_winner),
    .i_data(datas),
    .o_data(w_mux_data)
  );

  assign w_cap  = (r_state == ARB_IDLE) | ((r_state == ARB_FULL) & out_ready);
  // Gated by rst_n so no grant is shown while reset is held.
  assign w_fire = rst_n & w_cap & w_any;

  always_comb begin
    gnt = '0;
    if (w_fire) gnt[w_winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '1;
      r_sel   <= '0;
      r_data  <= '0;
`ifdef ARB_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else if (w_cap) begin
      if (w_any) begin
        r_state <= ARB_FULL;
        r_ptr   <= w_winner;
        r_sel   <= w_winner;
        r_data  <= w_mux_data;
`ifdef ARB_LOCK_EN
        r_lock_hold <= lock[w_winner];
`endif
      end else begin
        // Drain: word consumed and nothing new; data/sel keep their last values.
        r_state <= ARB_IDLE;
      end
    end
  end

  assign out_valid = (r_state == ARB_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench: tb_rr_mux_arbiter
// Directed scenarios plus a randomized run, all checked against a behavioural model.
module tb_rr_mux_arbiter;

  localparam int SW = 3;
  localparam int DW = 8;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] datas;
  logic            out_ready;
`ifdef ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_sel;
  int            m_ptr;
  logic          m_hold;

  // Per-cycle samples: gnt observed / expected before the edge.
  logic [N-1:0]  s_gnt;
  logic [N-1:0]  e_gnt;

  always #5 clk = ~clk;

  rr_mux_arbiter #(
    .SELECT_WIDTH(SW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .datas    (datas),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = N - 1;
    m_hold  = 1'b0;
  endtask

  // Winner by the rules: held lock owner if still requesting, else first request after ptr.
  function automatic int pick();
    int idx;
`ifdef ARB_LOCK_EN
    if (m_hold && req[m_ptr]) return m_ptr;
`endif
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_default_datas();
    for (int i = 0; i < N; i++) datas[i*DW +: DW] = 8'h10 + 8'(i);
  endtask

  // One clock: sample gnt at the falling edge, advance the model at the rising edge,
  // return #1 later so callers can compare registered outputs.
  task automatic cycle();
    int   w;
    logic cap;
    @(negedge clk);
    cap   = !m_valid || out_ready;
    w     = pick();
    e_gnt = '0;
    if (rst_n && cap && w >= 0) e_gnt[w] = 1'b1;
    s_gnt = gnt;
    @(posedge clk);
    if (cap) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = datas[w*DW +: DW];
        m_sel   = w;
        m_ptr   = w;
`ifdef ARB_LOCK_EN
        m_hold  = lock[w];
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = '1;
    out_ready = 1'b1;
    set_default_datas();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL rst_data got %h want 00", out_data); end
    n_checks++; if (out_sel !== 3'd0) begin n_errors++; $display("FAIL rst_sel got %0d want 0", out_sel); end
    n_checks++; if (gnt !== 8'h00) begin n_errors++; $display("FAIL rst_gnt got %b want 0", gnt); end
    rst_n = 1'b1;
    cycle();
    n_checks++; if (s_gnt !== 8'h01) begin n_errors++; $display("FAIL rst_first_gnt got %b want 00000001", s_gnt); end
    n_checks++; if (out_data !== 8'h10 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL rst_first_word got %h/%b want 10/1", out_data, out_valid);
    end
    // Stall with a word held, then reset in the middle of the transfer.
    out_ready = 1'b0;
    cycle();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_held_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL rst_async_data got %h want 00", out_data); end
    n_checks++; if (out_sel !== 3'd0) begin n_errors++; $display("FAIL rst_async_sel got %0d want 0", out_sel); end
    n_checks++; if (gnt !== 8'h00) begin n_errors++; $display("FAIL rst_async_gnt got %b want 0", gnt); end
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    cycle();
    n_checks++; if (s_gnt !== 8'h01 || out_sel !== 3'd0) begin
      n_errors++; $display("FAIL rst_release_first got gnt %b sel %0d want 00000001 sel 0", s_gnt, out_sel);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_checks++; if (out_sel !== 3'(k % N)) begin n_errors++; $display("FAIL rot_sel[%0d] got %0d want %0d", k, out_sel, k % N); end
      n_checks++; if (out_data !== 8'h10 + 8'(k % N)) begin
        n_errors++; $display("FAIL rot_data[%0d] got %h want %h", k, out_data, 8'h10 + 8'(k % N));
      end
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rot_valid[%0d] got %b want 1", k, out_valid); end
      n_checks++; if (s_gnt !== e_gnt) begin n_errors++; $display("FAIL rot_gnt[%0d] got %b want %b", k, s_gnt, e_gnt); end
    end
  endtask

  task automatic test_sparse_wrap();
    int exp_sel[3];
    exp_sel = '{0, 2, 0};
    req = 8'b0100_0000;
    cycle();
    n_checks++; if (out_sel !== 3'd6) begin n_errors++; $display("FAIL wrap_setup got %0d want 6", out_sel); end
    req = 8'b0000_0101;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++; if (out_sel !== 3'(exp_sel[k]) || out_data !== 8'h10 + 8'(exp_sel[k])) begin
        n_errors++; $display("FAIL wrap_pick[%0d] got sel %0d data %h want %0d", k, out_sel, out_data, exp_sel[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] held_sel;
    logic [DW-1:0] held_data;
    logic [N-1:0]  want;
    req = '1;
    out_ready = 1'b1;
    cycle();
    held_sel  = out_sel;
    held_data = out_data;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++; if (s_gnt !== 8'h00) begin n_errors++; $display("FAIL bp_gnt[%0d] got %b want 0", k, s_gnt); end
      n_checks++; if (out_sel !== held_sel || out_data !== held_data || out_valid !== 1'b1) begin
        n_errors++; $display("FAIL bp_frozen[%0d] got %0d/%h want %0d/%h", k, out_sel, out_data, held_sel, held_data);
      end
    end
    out_ready = 1'b1;
    want = '0;
    want[(int'(held_sel) + 1) % N] = 1'b1;
    cycle();
    n_checks++; if (s_gnt !== want || out_sel !== 3'((int'(held_sel) + 1) % N)) begin
      n_errors++; $display("FAIL bp_resume got gnt %b sel %0d want %b", s_gnt, out_sel, want);
    end
  endtask

  task automatic test_drain();
    req = '0;
    out_ready = 1'b1;
    cycle();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_idle got %b want 0", out_valid); end
    req = 8'b0000_1000;
    cycle();
    n_checks++; if (s_gnt !== 8'b0000_1000) begin n_errors++; $display("FAIL drain_gnt got %b want 00001000", s_gnt); end
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 8'h13) begin
      n_errors++; $display("FAIL drain_word got %b/%0d/%h want 1/3/13", out_valid, out_sel, out_data);
    end
    req = '0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_checks++; if (out_valid !== 1'b0 || out_sel !== 3'd3 || out_data !== 8'h13) begin
        n_errors++; $display("FAIL drain_after[%0d] got %b/%0d/%h want 0/3/13", k, out_valid, out_sel, out_data);
      end
      n_checks++; if (s_gnt !== 8'h00) begin n_errors++; $display("FAIL drain_nognt[%0d] got %b want 0", k, s_gnt); end
    end
  endtask

  task automatic test_lock();
    int exp_sel[6];
`ifdef ARB_LOCK_EN
    exp_sel = '{2, 2, 2, 2, 3, 4};
    lock = '0;
`else
    exp_sel = '{2, 3, 4, 5, 6, 7};
`endif
    do_reset();
    req = '1;
    out_ready = 1'b1;
    repeat (2) cycle();
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_LOCK_EN
      lock = (k < 3) ? 8'h04 : 8'h00;
`endif
      cycle();
      n_checks++; if (out_sel !== 3'(exp_sel[k])) begin n_errors++; $display("FAIL lock_seq[%0d] got %0d want %0d", k, out_sel, exp_sel[k]); end
    end
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req       = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) datas[i*DW +: DW] = 8'($urandom);
`ifdef ARB_LOCK_EN
      lock = 8'($urandom) & 8'($urandom);
`endif
      cycle();
      n_checks++; if (s_gnt !== e_gnt) begin n_errors++; $display("FAIL rnd_gnt[%0d] got %b want %b", k, s_gnt, e_gnt); end
      n_checks++; if (out_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid[%0d] got %b want %b", k, out_valid, m_valid); end
      n_checks++; if (out_sel !== 3'(m_sel) || out_data !== m_data) begin
        n_errors++; $display("FAIL rnd_word[%0d] got %0d/%h want %0d/%h", k, out_sel, out_data, m_sel, m_data);
      end
    end
  endtask

  initial begin
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_backpressure();
    test_drain();
    test_lock();
    set_default_datas();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
